dcm_sequencer: RTL and testbench



---
 rtl/dcm_sequencer.sv | 140 ++++++++++++++
 tb/tb_dcm_sequencer.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/dcm_sequencer.sv
// DCM_SP power-up / lock-recovery sequencer running on the 50 MHz CLKIN net.
// Latency: locked is seen 2 cycles late (2-flop synchroniser); all outputs are registered.
// Backpressure: none; a lost lock triggers a bounded number of DCM resets, then a sticky fail.
module dcm_sequencer #(
  parameter int RST_CYCLES    = 8,
  parameter int LOCK_TIMEOUT  = 65535,
  parameter int STABLE_CYCLES = 1023,
  parameter int MAX_RETRIES   = 7
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       locked,
  output logic       dcm_reset,
  output logic       sys_reset,
  output logic       ready,
  output logic       fail,
  output logic [3:0] retries
);

  // One shared counter, sized for the largest of the three cycle-count parameters.
  localparam int MAX_A = (RST_CYCLES > LOCK_TIMEOUT) ? RST_CYCLES : LOCK_TIMEOUT;
  localparam int MAX_P = (MAX_A > STABLE_CYCLES) ? MAX_A : STABLE_CYCLES;
  localparam int CNT_W = $clog2(MAX_P + 1);

  localparam logic [CNT_W-1:0] RST_LAST    = CNT_W'(RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] STABLE_LAST = CNT_W'(STABLE_CYCLES - 1);
  localparam logic [3:0]       MAX_R       = 4'(MAX_RETRIES);

  typedef enum logic [2:0] {
    S_RST,
    S_WAIT_LOCK,
    S_STABLE,
    S_RUN,
    S_FAIL
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [3:0]       retries_q, retries_d;
  logic             dcm_reset_q, dcm_reset_d;
  logic             sys_reset_q, sys_reset_d;
  logic             ready_q, ready_d;
  logic             fail_q, fail_d;
  logic             sync0_q, locked_s_q;
  logic             retry;

  // Two-flop synchroniser for the asynchronous LOCKED signal.
  always_ff @(posedge clock) begin
    if (reset) begin
      sync0_q    <= 1'b0;
      locked_s_q <= 1'b0;
    end else begin
      sync0_q    <= locked;
      locked_s_q <= sync0_q;
    end
  end

  // Next-state, counter, retry bookkeeping and registered-output values.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    retries_d = retries_q;
    retry     = 1'b0;

    case (state_q)
      S_RST: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == RST_LAST) state_d = S_WAIT_LOCK;
      end
      S_WAIT_LOCK: begin
        cnt_d = cnt_q + CNT_W'(1);
        // Lock takes priority over a timeout landing on the same cycle.
        if (locked_s_q)                 state_d = S_STABLE;
        else if (cnt_q == TIMEOUT_LAST) retry   = 1'b1;
      end
      S_STABLE: begin
        cnt_d = cnt_q + CNT_W'(1);
        // Any dropout restarts from a fresh DCM reset, not just the stability count.
        if (!locked_s_q)               retry   = 1'b1;
        else if (cnt_q == STABLE_LAST) state_d = S_RUN;
      end
      S_RUN: begin
        if (!locked_s_q) retry = 1'b1;
      end
      S_FAIL: begin
        state_d = S_FAIL;
      end
      default: begin
        state_d = S_RST;
      end
    endcase

    // retries is bounded by MAX_RETRIES (<= 15), so it can never wrap.
    if (retry) begin
      if (retries_q < MAX_R) begin
        retries_d = retries_q + 4'd1;
        state_d   = S_RST;
      end else begin
        state_d   = S_FAIL;
      end
    end

    if (state_d != state_q) cnt_d = '0;

    // Outputs follow the state being entered so they change on the transition edge.
    dcm_reset_d = (state_d == S_RST) || (state_d == S_FAIL);
    sys_reset_d = (state_d != S_RUN);
    ready_d     = (state_d == S_RUN);
    fail_d      = (state_d == S_FAIL);
  end

  // State, counter, retry count and output registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= S_RST;
      cnt_q       <= '0;
      retries_q   <= 4'd0;
      dcm_reset_q <= 1'b1;
      sys_reset_q <= 1'b1;
      ready_q     <= 1'b0;
      fail_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      retries_q   <= retries_d;
      dcm_reset_q <= dcm_reset_d;
      sys_reset_q <= sys_reset_d;
      ready_q     <= ready_d;
      fail_q      <= fail_d;
    end
  end

  assign dcm_reset = dcm_reset_q;
  assign sys_reset = sys_reset_q;
  assign ready     = ready_q;
  assign fail      = fail_q;
  assign retries   = retries_q;

endmodule

// File: tb/tb_dcm_sequencer.sv
// Directed bench for dcm_sequencer with short timing parameters.
// Edge numbering: E0 is the last edge with reset high; "after Ek" means sampled 1 time unit past edge k.
// Inputs are changed right after sampling, so they are first seen by the DUT on the following edge.
module tb_dcm_sequencer;

  logic       clock = 1'b0;
  logic       reset;
  logic       locked;
  logic       dcm_reset;
  logic       sys_reset;
  logic       ready;
  logic       fail;
  logic [3:0] retries;

  int errors = 0;
  int checks = 0;
  int ecnt   = 0;

  dcm_sequencer #(
    .RST_CYCLES   (4),
    .LOCK_TIMEOUT (20),
    .STABLE_CYCLES(10),
    .MAX_RETRIES  (2)
  ) dut (
    .clock    (clock),
    .reset    (reset),
    .locked   (locked),
    .dcm_reset(dcm_reset),
    .sys_reset(sys_reset),
    .ready    (ready),
    .fail     (fail),
    .retries  (retries)
  );

  always #5 clock = ~clock;

  task automatic step();
    @(posedge clock);
    #1;
    ecnt++;
  endtask

  task automatic go(input int e);
    while (ecnt < e) step();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step();
    reset = 1'b0;
    ecnt  = 0;
  endtask

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_dcm"},   int'(dcm_reset), 1);
    chk({tag, "_sys"},   int'(sys_reset), 1);
    chk({tag, "_ready"}, int'(ready),     0);
    chk({tag, "_fail"},  int'(fail),      0);
    chk({tag, "_retry"}, int'(retries),   0);
  endtask

  // Output invariants, checked every cycle away from the active edge.
  always @(negedge clock) begin
    checks++;
    assert ((!ready || !sys_reset) && (!fail || dcm_reset) && !(ready && fail)) else begin
      errors++;
      $error("FAIL invariant: ready=%0b sys_reset=%0b fail=%0b dcm_reset=%0b",
             ready, sys_reset, fail, dcm_reset);
    end
  end

  initial begin
    reset  = 1'b1;
    locked = 1'b0;
    step();

    // Nominal power-up: lock arrives shortly after the DCM reset pulse.
    do_reset();
    chk_reset_vals("rst0");
    go(3);  chk("nom_dcm_e3", int'(dcm_reset), 1);
    go(4);  chk("nom_dcm_e4", int'(dcm_reset), 0);
    go(5);  locked = 1'b1;
    go(17); chk("nom_ready_e17", int'(ready), 0);
            chk("nom_sys_e17",   int'(sys_reset), 1);
    go(18); chk("nom_ready_e18", int'(ready), 1);
            chk("nom_sys_e18",   int'(sys_reset), 0);
            chk("nom_retries",   int'(retries), 0);

    // One-cycle glitch 5 cycles into STABLE, then loss of lock in RUN, then reset in STABLE.
    locked = 1'b0;
    do_reset();
    locked = 1'b1;
    go(9);  locked = 1'b0;
    go(10); locked = 1'b1;
    go(11); chk("gl_dcm_e11",   int'(dcm_reset), 0);
            chk("gl_retry_e11", int'(retries), 0);
    go(12); chk("gl_dcm_e12",   int'(dcm_reset), 1);
            chk("gl_retry_e12", int'(retries), 1);
            chk("gl_sys_e12",   int'(sys_reset), 1);
    go(26); chk("gl_ready_e26", int'(ready), 0);
    go(27); chk("gl_ready_e27", int'(ready), 1);
            chk("gl_sys_e27",   int'(sys_reset), 0);
            chk("gl_retry_e27", int'(retries), 1);
    go(29); locked = 1'b0;
    go(31); chk("loss_ready_e31", int'(ready), 1);
    go(32); chk("loss_ready_e32", int'(ready), 0);
            chk("loss_sys_e32",   int'(sys_reset), 1);
            chk("loss_dcm_e32",   int'(dcm_reset), 1);
            chk("loss_retry_e32", int'(retries), 2);
            locked = 1'b1;
    go(36); chk("relock_dcm_e36", int'(dcm_reset), 0);
    go(37); chk("relock_dcm_e37", int'(dcm_reset), 0);
            chk("relock_sys_e37", int'(sys_reset), 1);
            chk("relock_rdy_e37", int'(ready), 0);
    go(38);
    reset = 1'b1;
    step();
    reset = 1'b0;
    ecnt  = 0;
    chk_reset_vals("rst_stable");

    // Lock never arrives: two retries, then sticky FAIL.
    locked = 1'b0;
    do_reset();
    go(23);  chk("to_dcm_e23",    int'(dcm_reset), 0);
    go(24);  chk("to_dcm_e24",    int'(dcm_reset), 1);
             chk("to_retry_e24",  int'(retries), 1);
    go(27);  chk("to_dcm_e27",    int'(dcm_reset), 1);
    go(28);  chk("to_dcm_e28",    int'(dcm_reset), 0);
    go(47);  chk("to_dcm_e47",    int'(dcm_reset), 0);
             chk("to_retry_e47",  int'(retries), 1);
    go(48);  chk("to_dcm_e48",    int'(dcm_reset), 1);
             chk("to_retry_e48",  int'(retries), 2);
    go(71);  chk("to_fail_e71",   int'(fail), 0);
    go(72);  chk("to_fail_e72",   int'(fail), 1);
             chk("to_dcm_e72",    int'(dcm_reset), 1);
             chk("to_retry_e72",  int'(retries), 2);
             chk("to_ready_e72",  int'(ready), 0);
    go(100); chk("to_fail_e100",  int'(fail), 1);
             chk("to_dcm_e100",   int'(dcm_reset), 1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    ecnt  = 0;
    chk_reset_vals("rst_fail");
    go(4);   chk("post_fail_dcm_e4", int'(dcm_reset), 0);
             chk("post_fail_fail",   int'(fail), 0);

    // Lock becomes visible on the same cycle the timeout count is reached: lock wins.
    locked = 1'b0;
    do_reset();
    go(21); locked = 1'b1;
    go(23); chk("sim_dcm_e23",   int'(dcm_reset), 0);
    go(24); chk("sim_dcm_e24",   int'(dcm_reset), 0);
            chk("sim_retry_e24", int'(retries), 0);
    go(33); chk("sim_ready_e33", int'(ready), 0);
    go(34); chk("sim_ready_e34", int'(ready), 1);

    // One cycle later the timeout wins and a retry is taken.
    locked = 1'b0;
    do_reset();
    go(22); locked = 1'b1;
    go(24); chk("late_dcm_e24",   int'(dcm_reset), 1);
            chk("late_retry_e24", int'(retries), 1);

    @(negedge clock);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
